decode: RTL and testbench

//  Second pipeline stage: consumes the instruction word, NPC and tag produced by fetch.

---
 rtl/decode.sv | 203 ++++++++++++++++++++
 tb/tb_decode.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode
// Second pipeline stage. Turns the fetched instruction word into an execution
// unit, an encoding format, register indexes and a sign-extended immediate.
// It also detects load-use hazards: fetch is held and one bubble is issued.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   stall            global stall; every register holds
//   instruction      instruction word from memory (aligned with NPC_in)
//   NPC_in, tag_in   PC and tag of that instruction, from fetch
//   rs1, rs2         source indexes to the register bank (combinational)
//   hazard           combinational load-use interlock back to fetch
//   rd_out, imm_out, format_out, unit_out, instruction_out,
//   NPC_out, tag_out, valid_out
//                    registered decode results for execute
// ---------------------------------------------------------------------------
module decode #(
  parameter logic [31:0] BUBBLE_INSTR   = 32'h00000013,
  parameter logic        LOAD_HAZARD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instruction,
  input  logic [31:0] NPC_in,
  input  logic [3:0]  tag_in,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        hazard,
  output logic [4:0]  rd_out,
  output logic [31:0] imm_out,
  output logic [2:0]  format_out,
  output logic [2:0]  unit_out,
  output logic [31:0] instruction_out,
  output logic [31:0] NPC_out,
  output logic [3:0]  tag_out,
  output logic        valid_out
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [2:0] UNIT_ADDER   = 3'd0;
  localparam logic [2:0] UNIT_LOGIC   = 3'd1;
  localparam logic [2:0] UNIT_SHIFTER = 3'd2;
  localparam logic [2:0] UNIT_BRANCH  = 3'd3;
  localparam logic [2:0] UNIT_JUMP    = 3'd4;
  localparam logic [2:0] UNIT_MEMORY  = 3'd5;
  localparam logic [2:0] UNIT_CSR     = 3'd6;
  localparam logic [2:0] UNIT_ILLEGAL = 3'd7;

  logic [6:0]  opcode;
  logic [4:0]  inst_rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]  alu_unit;

  logic [2:0]  dec_unit;
  logic [2:0]  dec_format;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic        is_load;

  logic        lock_valid;
  logic [4:0]  lock_rd;

  assign opcode  = instruction[6:0];
  assign inst_rd = instruction[11:7];
  assign rs1     = instruction[19:15];
  assign rs2     = instruction[24:20];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  // Register/immediate ALU ops pick their unit from funct3 alone; the
  // add/sub and srl/sra distinctions are left to execute via funct7.
  always_comb begin
    alu_unit = UNIT_ADDER;
    case (instruction[14:12])
      3'b001, 3'b101:         alu_unit = UNIT_SHIFTER;
      3'b100, 3'b110, 3'b111: alu_unit = UNIT_LOGIC;
      default:                alu_unit = UNIT_ADDER;
    endcase
  end

  // Main decode. Unknown opcodes (which includes any word whose low two
  // bits are not 2'b11) fall through to ILLEGAL with no destination and no
  // source usage, so they can never create or trigger an interlock.
  always_comb begin
    dec_unit   = UNIT_ILLEGAL;
    dec_format = FMT_R;
    dec_imm    = 32'd0;
    dec_rd     = 5'd0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    is_load    = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        dec_unit = UNIT_ADDER; dec_format = FMT_U; dec_imm = imm_u; dec_rd = inst_rd;
      end
      OP_JAL: begin
        dec_unit = UNIT_JUMP; dec_format = FMT_J; dec_imm = imm_j; dec_rd = inst_rd;
      end
      OP_JALR: begin
        dec_unit = UNIT_JUMP; dec_format = FMT_I; dec_imm = imm_i; dec_rd = inst_rd;
        use_rs1  = 1'b1;
      end
      OP_BRANCH: begin
        dec_unit = UNIT_BRANCH; dec_format = FMT_B; dec_imm = imm_b;
        use_rs1  = 1'b1; use_rs2 = 1'b1;
      end
      OP_LOAD: begin
        dec_unit = UNIT_MEMORY; dec_format = FMT_I; dec_imm = imm_i; dec_rd = inst_rd;
        use_rs1  = 1'b1; is_load = 1'b1;
      end
      OP_STORE: begin
        dec_unit = UNIT_MEMORY; dec_format = FMT_S; dec_imm = imm_s;
        use_rs1  = 1'b1; use_rs2 = 1'b1;
      end
      OP_IMM: begin
        dec_unit = alu_unit; dec_format = FMT_I; dec_imm = imm_i; dec_rd = inst_rd;
        use_rs1  = 1'b1;
      end
      OP_REG: begin
        dec_unit = alu_unit; dec_format = FMT_R; dec_rd = inst_rd;
        use_rs1  = 1'b1; use_rs2 = 1'b1;
      end
      OP_SYSTEM: begin
        dec_unit = UNIT_CSR; dec_format = FMT_I; dec_imm = imm_i; dec_rd = inst_rd;
        use_rs1  = 1'b1;
      end
      default: ;
    endcase
  end

  // The lock only ever holds a non-zero rd, but x0 sources are excluded
  // explicitly as well so x0 can never interlock.
  assign hazard = LOAD_HAZARD_EN & lock_valid &
                  ((use_rs1 & (rs1 != 5'd0) & (rs1 == lock_rd)) |
                   (use_rs2 & (rs2 != 5'd0) & (rs2 == lock_rd)));

  // Pipeline register and load lock. A hazard edge issues a bubble and
  // clears the lock, so the held instruction decodes normally next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_out          <= 5'd0;
      imm_out         <= 32'd0;
      format_out      <= FMT_R;
      unit_out        <= UNIT_ADDER;
      instruction_out <= BUBBLE_INSTR;
      NPC_out         <= 32'd0;
      tag_out         <= 4'd0;
      valid_out       <= 1'b0;
      lock_valid      <= 1'b0;
      lock_rd         <= 5'd0;
    end else if (!stall) begin
      NPC_out <= NPC_in;
      tag_out <= tag_in;
      if (hazard) begin
        rd_out          <= 5'd0;
        imm_out         <= 32'd0;
        format_out      <= FMT_I;
        unit_out        <= UNIT_ADDER;
        instruction_out <= BUBBLE_INSTR;
        valid_out       <= 1'b0;
        lock_valid      <= 1'b0;
        lock_rd         <= 5'd0;
      end else begin
        rd_out          <= dec_rd;
        imm_out         <= dec_imm;
        format_out      <= dec_format;
        unit_out        <= dec_unit;
        instruction_out <= instruction;
        valid_out       <= 1'b1;
        lock_valid      <= is_load & (dec_rd != 5'd0);
        lock_rd         <= dec_rd;
      end
    end
  end

endmodule

// File: tb/tb_decode.sv
// ---------------------------------------------------------------------------
// tb_decode
// Directed test of decode. A second instance with the load interlock
// disabled shares all inputs so both settings are observed on one stream.
// ---------------------------------------------------------------------------
module tb_decode;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] NPC_in;
  logic [3:0]  tag_in;

  logic [4:0]  rs1, rs2, rd_out;
  logic        hazard, valid_out;
  logic [31:0] imm_out, instruction_out, NPC_out;
  logic [2:0]  format_out, unit_out;
  logic [3:0]  tag_out;

  logic [4:0]  n_rs1, n_rs2, n_rd_out;
  logic        n_hazard, n_valid_out;
  logic [31:0] n_imm_out, n_instruction_out, n_NPC_out;
  logic [2:0]  n_format_out, n_unit_out;
  logic [3:0]  n_tag_out;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] LW_X2   = 32'h0000A103;
  localparam logic [31:0] ADD_X3  = 32'h001101B3;
  localparam logic [31:0] SW_X2   = 32'hFE20AE23;
  localparam logic [31:0] JAL_X1  = 32'h010000EF;
  localparam logic [31:0] LW_X0   = 32'h0000A003;
  localparam logic [31:0] ADD_X0  = 32'h001001B3;

  decode dut (
    .clk(clk), .reset(reset), .stall(stall), .instruction(instruction),
    .NPC_in(NPC_in), .tag_in(tag_in), .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .rd_out(rd_out), .imm_out(imm_out), .format_out(format_out),
    .unit_out(unit_out), .instruction_out(instruction_out), .NPC_out(NPC_out),
    .tag_out(tag_out), .valid_out(valid_out)
  );

  decode #(.LOAD_HAZARD_EN(1'b0)) dut_nohz (
    .clk(clk), .reset(reset), .stall(stall), .instruction(instruction),
    .NPC_in(NPC_in), .tag_in(tag_in), .rs1(n_rs1), .rs2(n_rs2), .hazard(n_hazard),
    .rd_out(n_rd_out), .imm_out(n_imm_out), .format_out(n_format_out),
    .unit_out(n_unit_out), .instruction_out(n_instruction_out), .NPC_out(n_NPC_out),
    .tag_out(n_tag_out), .valid_out(n_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] w, input logic [31:0] npc, input logic [3:0] tg);
    instruction = w;
    NPC_in      = npc;
    tag_in      = tg;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    present(NOP, 32'h0, 4'h0);
    step();
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", valid_out); end
    checks++; if (instruction_out !== 32'h00000013) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 00000013", instruction_out); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL reset_hazard: got %0h expected 0", hazard); end
    checks++; if (tag_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_tag: got %0h expected 0", tag_out); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("[TB] FAIL reset_rd: got %0d expected 0", rd_out); end
    reset = 1'b0;
  endtask

  task automatic test_addi();
    present(ADDI_X1, 32'h100, 4'h1);
    step();
    checks++; if (unit_out !== 3'd0) begin errors++; $display("[TB] FAIL addi_unit: got %0d expected 0", unit_out); end
    checks++; if (format_out !== 3'd1) begin errors++; $display("[TB] FAIL addi_format: got %0d expected 1", format_out); end
    checks++; if (rd_out !== 5'd1) begin errors++; $display("[TB] FAIL addi_rd: got %0d expected 1", rd_out); end
    checks++; if (imm_out !== 32'd5) begin errors++; $display("[TB] FAIL addi_imm: got %h expected 00000005", imm_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL addi_valid: got %0h expected 1", valid_out); end
    checks++; if (NPC_out !== 32'h100) begin errors++; $display("[TB] FAIL addi_npc: got %h expected 00000100", NPC_out); end
    checks++; if (tag_out !== 4'h1) begin errors++; $display("[TB] FAIL addi_tag: got %0h expected 1", tag_out); end
  endtask

  task automatic test_load_use();
    present(LW_X2, 32'h104, 4'h2);
    checks++; if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL lw_prehazard: got %0h expected 0", hazard); end
    step();
    checks++; if (unit_out !== 3'd5) begin errors++; $display("[TB] FAIL lw_unit: got %0d expected 5", unit_out); end
    checks++; if (rd_out !== 5'd2) begin errors++; $display("[TB] FAIL lw_rd: got %0d expected 2", rd_out); end
    present(ADD_X3, 32'h108, 4'h3);
    checks++; if (rs1 !== 5'd2) begin errors++; $display("[TB] FAIL add_rs1: got %0d expected 2", rs1); end
    checks++; if (rs2 !== 5'd1) begin errors++; $display("[TB] FAIL add_rs2: got %0d expected 1", rs2); end
    checks++; if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL lu_hazard: got %0h expected 1", hazard); end
    checks++; if (n_hazard !== 1'b0) begin errors++; $display("[TB] FAIL nohz_hazard: got %0h expected 0", n_hazard); end
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL bubble_valid: got %0h expected 0", valid_out); end
    checks++; if (instruction_out !== NOP) begin errors++; $display("[TB] FAIL bubble_instr: got %h expected 00000013", instruction_out); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("[TB] FAIL bubble_rd: got %0d expected 0", rd_out); end
    checks++; if (NPC_out !== 32'h108) begin errors++; $display("[TB] FAIL bubble_npc: got %h expected 00000108", NPC_out); end
    checks++; if (tag_out !== 4'h3) begin errors++; $display("[TB] FAIL bubble_tag: got %0h expected 3", tag_out); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL hazard_one_cycle: got %0h expected 0", hazard); end
    checks++; if (n_valid_out !== 1'b1 || n_rd_out !== 5'd3) begin errors++; $display("[TB] FAIL nohz_issue: got valid=%0h rd=%0d expected valid=1 rd=3", n_valid_out, n_rd_out); end
    step();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %0h expected 1", valid_out); end
    checks++; if (rd_out !== 5'd3) begin errors++; $display("[TB] FAIL add_rd: got %0d expected 3", rd_out); end
    checks++; if (unit_out !== 3'd0) begin errors++; $display("[TB] FAIL add_unit: got %0d expected 0", unit_out); end
  endtask

  task automatic test_store_jal();
    present(SW_X2, 32'h10C, 4'h4);
    step();
    checks++; if (imm_out !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL sw_imm: got %h expected fffffffc", imm_out); end
    checks++; if (format_out !== 3'd2) begin errors++; $display("[TB] FAIL sw_format: got %0d expected 2", format_out); end
    checks++; if (unit_out !== 3'd5) begin errors++; $display("[TB] FAIL sw_unit: got %0d expected 5", unit_out); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("[TB] FAIL sw_rd: got %0d expected 0", rd_out); end
    present(JAL_X1, 32'h110, 4'h5);
    step();
    checks++; if (imm_out !== 32'd16) begin errors++; $display("[TB] FAIL jal_imm: got %h expected 00000010", imm_out); end
    checks++; if (unit_out !== 3'd4) begin errors++; $display("[TB] FAIL jal_unit: got %0d expected 4", unit_out); end
    checks++; if (format_out !== 3'd5) begin errors++; $display("[TB] FAIL jal_format: got %0d expected 5", format_out); end
    checks++; if (rd_out !== 5'd1) begin errors++; $display("[TB] FAIL jal_rd: got %0d expected 1", rd_out); end
  endtask

  task automatic test_illegal_stall();
    present(32'hFFFFFFFF, 32'h114, 4'h6);
    step();
    checks++; if (unit_out !== 3'd7) begin errors++; $display("[TB] FAIL illegal_unit: got %0d expected 7", unit_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL illegal_valid: got %0h expected 1", valid_out); end
    present(LW_X2, 32'h118, 4'h7);
    step();
    present(ADD_X3, 32'h11C, 4'h8);
    checks++; if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL stall_pre_hazard: got %0h expected 1", hazard); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      NPC_in = 32'h200 + i;
      step();
      checks++; if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL stall_lock_%0d: got %0h expected 1", i, hazard); end
      checks++; if (instruction_out !== LW_X2 || valid_out !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold_%0d: got %h/%0h expected %h/1", i, instruction_out, valid_out, LW_X2); end
      checks++; if (NPC_out !== 32'h118) begin errors++; $display("[TB] FAIL stall_npc_%0d: got %h expected 00000118", i, NPC_out); end
    end
    stall = 1'b0;
    NPC_in = 32'h11C;
    step();
    checks++; if (valid_out !== 1'b0 || instruction_out !== NOP) begin errors++; $display("[TB] FAIL stall_bubble: got %0h/%h expected 0/00000013", valid_out, instruction_out); end
    step();
    checks++; if (valid_out !== 1'b1 || rd_out !== 5'd3) begin errors++; $display("[TB] FAIL stall_add: got valid=%0h rd=%0d expected 1/3", valid_out, rd_out); end
  endtask

  task automatic test_x0();
    present(LW_X0, 32'h120, 4'h9);
    step();
    present(ADD_X0, 32'h124, 4'hA);
    checks++; if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL x0_hazard: got %0h expected 0", hazard); end
    step();
    checks++; if (valid_out !== 1'b1 || rd_out !== 5'd3) begin errors++; $display("[TB] FAIL x0_issue: got valid=%0h rd=%0d expected 1/3", valid_out, rd_out); end
  endtask

  task automatic test_reset_during_hazard();
    present(LW_X2, 32'h128, 4'hB);
    step();
    present(ADD_X3, 32'h12C, 4'hC);
    checks++; if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_hazard: got %0h expected 1", hazard); end
    reset = 1'b1;
    stall = 1'b1;
    step();
    checks++; if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL rst_hazard_cleared: got %0h expected 0", hazard); end
    checks++; if (valid_out !== 1'b0 || instruction_out !== NOP) begin errors++; $display("[TB] FAIL rst_outputs: got %0h/%h expected 0/00000013", valid_out, instruction_out); end
    reset = 1'b0;
    stall = 1'b0;
    step();
    checks++; if (valid_out !== 1'b1 || rd_out !== 5'd3 || tag_out !== 4'hC) begin errors++; $display("[TB] FAIL rst_first_decode: got valid=%0h rd=%0d tag=%0h expected 1/3/c", valid_out, rd_out, tag_out); end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    instruction = NOP;
    NPC_in = 32'h0;
    tag_in = 4'h0;
    test_reset();
    test_addi();
    test_load_use();
    test_store_jal();
    test_illegal_stall();
    test_x0();
    test_reset_during_hazard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
